raw_video_gen: RTL and testbench
================================

RAW_VIDEO_GEN -- requirements
Module: raw_video_gen

Interface
REQ-001 SHALL have parameter source_h, default 1024: active pixels per line.
REQ-002 SHALL have parameter source_v, default 1024: active lines per frame.
REQ-003 SHALL have parameters H_SYNC=4, H_BACK=8, H_FRONT=8, V_SYNC=2, V_BACK=2, V_FRONT=2: blanking lengths, in pixels (H_*) or lines (V_*).
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: run request.
REQ-007 SHALL have port pattern_mode, input, 2: pattern select.
REQ-008 SHALL have port pattern_value, input, 8: flat-field level.
REQ-009 SHALL have ports out_vsync, out_hsync, out_den, outputs, 1 each: RAW stream timing, matching the ISP input side.
REQ-010 SHALL have port out_data, output, 8: Bayer RGGB RAW pixel.
REQ-011 SHALL have port busy, output, 1: high while in RUN.
REQ-012 SHALL have port frame_done, output, 1: single-cycle end-of-frame pulse.

Function
REQ-013 SHALL define H_TOTAL = H_SYNC+H_BACK+source_h+H_FRONT and V_TOTAL = V_SYNC+V_BACK+source_v+V_FRONT.
REQ-014 SHALL implement a two-state FSM, IDLE and RUN.
REQ-015 SHALL go IDLE->RUN on the first cycle enable=1, with h_cnt=0 and v_cnt=0.
REQ-016 SHALL, in RUN, increment h_cnt every cycle; it wraps at H_TOTAL-1 and then increments v_cnt, which wraps at V_TOTAL-1.
REQ-017 SHALL evaluate the last-pixel cycle (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1): enable=0 -> IDLE; enable=1 -> stay in RUN with a new frame.
REQ-018 SHALL ignore enable deasserted mid-frame; the current frame always completes.
REQ-019 SHALL assert out_vsync for whole lines with v_cnt < V_SYNC.
REQ-020 SHALL assert out_hsync when h_cnt < H_SYNC, on every line including vertical blanking.
REQ-021 SHALL assert out_den when H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+source_h and V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+source_v.
REQ-022 SHALL register all outputs, so they reflect the counter state of the previous cycle (latency 1 clk); out_data is aligned with out_den.
REQ-023 SHALL latch pattern_mode and pattern_value at frame start (h_cnt=0, v_cnt=0) and ignore changes mid-frame.
REQ-024 SHALL define x and y as active-area pixel and line indices; frame_cnt is an 8-bit frame counter that increments at frame end and wraps 255->0.
REQ-025 SHALL generate mode 0 (ramp): out_data = x[7:0].
REQ-026 SHALL generate mode 1 (Bayer bars): out_data = 8'hFF when x[0]=0 and y[0]=0 (R), 8'h80 on G sites, 8'h40 on B sites.
REQ-027 SHALL generate mode 2 (flat): out_data = latched pattern_value.
REQ-028 SHALL generate mode 3 (checker): out_data = (x[7:0]^y[7:0]) + frame_cnt, modulo 256.
REQ-029 SHALL drive out_data = 0 whenever out_den = 0.
REQ-030 SHALL pulse frame_done for exactly one cycle, in the cycle after the last-pixel cycle.
REQ-031 SHALL drive out_vsync, out_hsync and out_den all 0 while in IDLE.

Reset
REQ-032 SHALL, on reset=1 at a clk edge, force state IDLE, h_cnt=0, v_cnt=0, frame_cnt=0 and all outputs 0, including mid-frame.
REQ-033 SHALL give reset priority over enable.
REQ-034 SHALL, with enable=1 at reset release, start a frame one cycle after reset falls.

Structure
REQ-035 SHALL place the pattern_mode encodings and the default blanking constants in a shared isp_pkg.
REQ-036 SHALL contain one natural sub-module, raw_pattern_unit, which maps x, y, frame_cnt and mode to the pixel value; timing counters and the FSM stay in the top module.

Verification
Scenarios use source_h=8, source_v=4, and all blanking values = 2 (H_TOTAL=14, V_TOTAL=10).
REQ-037 SHALL cover ramp: mode 0, enable held -> each active line carries out_data 0..7 with out_den high for 8 cycles, 4 active lines per frame, frame_done every 140 cycles.
REQ-038 SHALL cover Bayer bars: mode 1 -> line 0 = FF,80,FF,80...; line 1 = 80,40,80,40...; out_data = 0 in blanking.
REQ-039 SHALL cover mid-frame disable: enable drops at cycle 50 -> frame completes, frame_done pulses, busy falls and all outputs hold 0.
REQ-040 SHALL cover mid-frame mode change: pattern_mode 2->0 at cycle 60 with pattern_value=8'h5A -> the rest of that frame stays 5A, and the next frame is a ramp.
REQ-041 SHALL cover reset mid-frame: reset pulsed at cycle 70 -> next cycle all outputs 0; a new frame restarts with out_hsync high for 2 cycles.
REQ-042 SHALL cover checker wrap: mode 3 across 257 frames -> pixel (0,0) of frame 256 equals 0, confirming the frame_cnt wrap.

Source files
------------

// File: rtl/isp_pkg.sv
// Constants shared by the ISP front-end blocks: pattern encodings, default
// blanking lengths and Bayer site levels.
package isp_pkg;

  localparam int unsigned CntW = 16;

  localparam int unsigned DefHSync  = 4;
  localparam int unsigned DefHBack  = 8;
  localparam int unsigned DefHFront = 8;
  localparam int unsigned DefVSync  = 2;
  localparam int unsigned DefVBack  = 2;
  localparam int unsigned DefVFront = 2;

  typedef enum logic [1:0] {
    PatRamp    = 2'd0,
    PatBayer   = 2'd1,
    PatFlat    = 2'd2,
    PatChecker = 2'd3
  } pattern_mode_e;

  localparam logic [7:0] BayerR = 8'hFF;
  localparam logic [7:0] BayerG = 8'h80;
  localparam logic [7:0] BayerB = 8'h40;

  // RGGB tiling: R at (even, even), B at (odd, odd), G elsewhere.
  function automatic logic [7:0] bayer_level(input logic x_odd, input logic y_odd);
    logic [7:0] level;
    case ({y_odd, x_odd})
      2'b00:   level = BayerR;
      2'b11:   level = BayerB;
      default: level = BayerG;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/raw_pattern_unit.sv
// Maps active-area coordinates, frame count and latched mode to one RAW pixel.
module raw_pattern_unit
  import isp_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [7:0] frame_cnt,
  input  logic [1:0] mode,
  input  logic [7:0] flat_value,
  output logic [7:0] pixel
);

  pattern_mode_e mode_e;
  assign mode_e = pattern_mode_e'(mode);

  always_comb begin
    pixel = '0;
    case (mode_e)
      PatRamp:    pixel = x;
      PatBayer:   pixel = bayer_level(x[0], y[0]);
      PatFlat:    pixel = flat_value;
      PatChecker: pixel = (x ^ y) + frame_cnt;
      default:    pixel = '0;
    endcase
  end

endmodule

// File: rtl/raw_video_gen.sv
// RAW Bayer test-pattern source: frame timing counters, run/idle control and
// registered sync/data outputs one cycle behind the counters.
module raw_video_gen
  import isp_pkg::*;
#(
  parameter int unsigned source_h = 1024,
  parameter int unsigned source_v = 1024,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BACK   = DefHBack,
  parameter int unsigned H_FRONT  = DefHFront,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BACK   = DefVBack,
  parameter int unsigned V_FRONT  = DefVFront
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_mode,
  input  logic [7:0] pattern_value,
  output logic       out_vsync,
  output logic       out_hsync,
  output logic       out_den,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + source_h + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + source_v + V_FRONT;

  localparam logic [CntW-1:0] HLast     = CntW'(H_TOTAL - 1);
  localparam logic [CntW-1:0] VLast     = CntW'(V_TOTAL - 1);
  localparam logic [CntW-1:0] HSyncEnd  = CntW'(H_SYNC);
  localparam logic [CntW-1:0] VSyncEnd  = CntW'(V_SYNC);
  localparam logic [CntW-1:0] HActStart = CntW'(H_SYNC + H_BACK);
  localparam logic [CntW-1:0] HActEnd   = CntW'(H_SYNC + H_BACK + source_h);
  localparam logic [CntW-1:0] VActStart = CntW'(V_SYNC + V_BACK);
  localparam logic [CntW-1:0] VActEnd   = CntW'(V_SYNC + V_BACK + source_v);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic            state_q, state_d;
  logic [CntW-1:0] h_cnt_q, h_cnt_d;
  logic [CntW-1:0] v_cnt_q, v_cnt_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [1:0]      mode_q;
  logic [7:0]      value_q;

  logic            running;
  logic            h_last;
  logic            v_last;
  logic            last_pixel;
  logic            frame_start;
  logic            hsync_d;
  logic            vsync_d;
  logic            den_d;
  logic [7:0]      x;
  logic [7:0]      y;
  logic [7:0]      pixel;

  assign running     = (state_q == StRun);
  assign h_last      = (h_cnt_q == HLast);
  assign v_last      = (v_cnt_q == VLast);
  assign last_pixel  = running && h_last && v_last;
  assign frame_start = running && (h_cnt_q == '0) && (v_cnt_q == '0);

  // Enable is only consulted in IDLE and on the last pixel, so a frame in
  // flight always runs to completion.
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end
      end
      default: begin
        if (h_last) begin
          h_cnt_d = '0;
          if (v_last) begin
            v_cnt_d     = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (!enable) begin
              state_d = StIdle;
            end
          end else begin
            v_cnt_d = v_cnt_q + CntW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + CntW'(1);
        end
      end
    endcase
  end

  assign hsync_d = running && (h_cnt_q < HSyncEnd);
  assign vsync_d = running && (v_cnt_q < VSyncEnd);
  assign den_d   = running &&
                   (h_cnt_q >= HActStart) && (h_cnt_q < HActEnd) &&
                   (v_cnt_q >= VActStart) && (v_cnt_q < VActEnd);

  assign x = 8'(h_cnt_q - HActStart);
  assign y = 8'(v_cnt_q - VActStart);

  raw_pattern_unit u_pattern (
    .x          (x),
    .y          (y),
    .frame_cnt  (frame_cnt_q),
    .mode       (mode_q),
    .flat_value (value_q),
    .pixel      (pixel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      mode_q      <= '0;
      value_q     <= '0;
      out_hsync   <= 1'b0;
      out_vsync   <= 1'b0;
      out_den     <= 1'b0;
      out_data    <= '0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      if (frame_start) begin
        mode_q  <= pattern_mode;
        value_q <= pattern_value;
      end
      out_hsync  <= hsync_d;
      out_vsync  <= vsync_d;
      out_den    <= den_d;
      out_data   <= den_d ? pixel : 8'h00;
      frame_done <= last_pixel;
    end
  end

  assign busy = running;

endmodule

// File: tb/tb_raw_video_gen.sv
// Self-checking bench for raw_video_gen against a frame-position reference model.
module tb_raw_video_gen;

  localparam int SH = 8;
  localparam int SV = 4;
  localparam int HS = 2;
  localparam int HB = 2;
  localparam int HF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VF = 2;
  localparam int HT = HS + HB + SH + HF;
  localparam int VT = VS + VB + SV + VF;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pattern_mode = 2'd0;
  logic [7:0] pattern_value = 8'h00;
  logic       out_vsync;
  logic       out_hsync;
  logic       out_den;
  logic [7:0] out_data;
  logic       busy;
  logic       frame_done;

  raw_video_gen #(
    .source_h (SH),
    .source_v (SV),
    .H_SYNC   (HS),
    .H_BACK   (HB),
    .H_FRONT  (HF),
    .V_SYNC   (VS),
    .V_BACK   (VB),
    .V_FRONT  (VF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pattern_mode  (pattern_mode),
    .pattern_value (pattern_value),
    .out_vsync     (out_vsync),
    .out_hsync     (out_hsync),
    .out_den       (out_den),
    .out_data      (out_data),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [12:0] act_bus;
  logic [12:0] exp_bus = '0;
  assign act_bus = {out_vsync, out_hsync, out_den, out_data, busy, frame_done};

  // Model: a running flag plus linear position inside the frame.
  int         m_run = 0;
  int         m_pos = 0;
  int         m_frame = 0;
  int         m_mode = 0;
  logic [7:0] m_val = 8'h00;

  function automatic logic [7:0] ref_pixel(int mode, int x, int y, int fc, logic [7:0] val);
    case (mode)
      0: return 8'(x % 256);
      1: begin
        if ((x % 2 == 0) && (y % 2 == 0)) return 8'hFF;
        if ((x % 2 == 1) && (y % 2 == 1)) return 8'h40;
        return 8'h80;
      end
      2: return val;
      default: return 8'(((x % 256) ^ (y % 256)) + fc);
    endcase
  endfunction

  task automatic model_step();
    int h, v, x, y;
    logic vs, hs, den, fd;
    logic [7:0] d;
    vs = 0; hs = 0; den = 0; fd = 0; d = 8'h00;
    if (reset) begin
      m_run = 0;
      m_pos = 0;
      m_frame = 0;
    end else if (m_run != 0) begin
      if (m_pos == 0) begin
        m_mode = int'(pattern_mode);
        m_val = pattern_value;
      end
      h = m_pos % HT;
      v = m_pos / HT;
      hs = (h < HS);
      vs = (v < VS);
      x = h - (HS + HB);
      y = v - (VS + VB);
      den = (x >= 0) && (x < SH) && (y >= 0) && (y < SV);
      if (den) d = ref_pixel(m_mode, x, y, m_frame, m_val);
      fd = (m_pos == FRAME - 1);
      if (fd) begin
        m_pos = 0;
        m_frame = (m_frame + 1) % 256;
        if (!enable) m_run = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end else if (enable) begin
      m_run = 1;
      m_pos = 0;
    end
    exp_bus = {vs, hs, den, d, (m_run != 0), fd};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'($urandom_range(0, 1));
    pattern_mode = 2'($urandom);
    pattern_value = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (act_bus !== 13'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %h want 0000", i, act_bus);
      end
    end
    reset = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if (act_bus !== exp_bus) begin
        n_fail++;
        $display("FAIL idle cyc %0d: got %h want %h", i, act_bus, exp_bus);
      end
    end
    // Start straight out of reset with enable already high.
    reset = 1'b1;
    enable = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    n_cmp++;
    if ({busy, out_hsync} !== 2'b10) begin
      n_fail++;
      $display("FAIL start_busy: got busy=%b hsync=%b want busy=1 hsync=0", busy, out_hsync);
    end
    cycle();
    n_cmp++;
    if ({out_vsync, out_hsync, out_den} !== 3'b110) begin
      n_fail++;
      $display("FAIL start_sync: got v/h/den=%b%b%b want 110", out_vsync, out_hsync, out_den);
    end
  endtask

  task automatic test_ramp();
    int den_run, den_frame, fd_last, fd_seen;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    enable = 1'b1;
    pattern_mode = 2'd0;
    den_run = 0; den_frame = 0; fd_last = -1; fd_seen = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      pattern_value = 8'($urandom);
      cycle();
      n_cmp++;
      if (act_bus !== exp_bus) begin
        n_fail++;
        $display("FAIL ramp cyc %0d: got %h want %h", i, act_bus, exp_bus);
      end
      if (out_den) begin
        den_run++;
        den_frame++;
      end else if (den_run != 0) begin
        n_cmp++;
        if (den_run != SH) begin
          n_fail++;
          $display("FAIL ramp_line_len cyc %0d: got %0d want %0d", i, den_run, SH);
        end
        den_run = 0;
      end
      if (frame_done) begin
        n_cmp++;
        if (den_frame != SH * SV) begin
          n_fail++;
          $display("FAIL ramp_den_count: got %0d want %0d", den_frame, SH * SV);
        end
        den_frame = 0;
        if (fd_last >= 0) begin
          n_cmp++;
          if (i - fd_last != FRAME) begin
            n_fail++;
            $display("FAIL ramp_period: got %0d want %0d", i - fd_last, FRAME);
          end
        end
        fd_last = i;
        fd_seen++;
      end
    end
    n_cmp++;
    if (fd_seen != 2) begin
      n_fail++;
      $display("FAIL ramp_frames: got %0d want 2", fd_seen);
    end
  endtask

  task automatic test_bayer();
    int k;
    logic [7:0] want;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    enable = 1'b1;
    pattern_mode = 2'd1;
    k = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      cycle();
      n_cmp++;
      if (act_bus !== exp_bus) begin
        n_fail++;
        $display("FAIL bayer cyc %0d: got %h want %h", i, act_bus, exp_bus);
      end
      if (!out_den) begin
        n_cmp++;
        if (out_data !== 8'h00) begin
          n_fail++;
          $display("FAIL bayer_blank cyc %0d: got %h want 00", i, out_data);
        end
      end else begin
        if (k < 2 * SH) begin
          if (k < SH) want = (k % 2 == 0) ? 8'hFF : 8'h80;
          else        want = (k % 2 == 0) ? 8'h80 : 8'h40;
          n_cmp++;
          if (out_data !== want) begin
            n_fail++;
            $display("FAIL bayer_px %0d: got %h want %h", k, out_data, want);
          end
        end
        k++;
      end
    end
  endtask

  task automatic test_mid_disable();
    int done_at;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    enable = 1'b1;
    pattern_mode = 2'($urandom);
    pattern_value = 8'($urandom);
    done_at = -1;
    for (int i = 0; i < 300; i++) begin
      if (i == 50) enable = 1'b0;
      cycle();
      n_cmp++;
      if (act_bus !== exp_bus) begin
        n_fail++;
        $display("FAIL disable cyc %0d: got %h want %h", i, act_bus, exp_bus);
      end
      if (done_at < 0 && frame_done) begin
        done_at = i;
        n_cmp++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL disable_busy: got %b want 0", busy);
        end
      end else if (done_at >= 0) begin
        n_cmp++;
        if (act_bus !== 13'h0) begin
          n_fail++;
          $display("FAIL disable_idle cyc %0d: got %h want 0000", i, act_bus);
        end
      end
    end
    n_cmp++;
    if (done_at < 0) begin
      n_fail++;
      $display("FAIL disable_done: got no frame_done want one within 300 cycles");
    end
  endtask

  task automatic test_mode_change();
    int fd, ramp_x;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    enable = 1'b1;
    pattern_mode = 2'd2;
    pattern_value = 8'h5A;
    fd = 0; ramp_x = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      if (i == 60) pattern_mode = 2'd0;
      if (i >= 60) pattern_value = 8'($urandom);
      cycle();
      n_cmp++;
      if (act_bus !== exp_bus) begin
        n_fail++;
        $display("FAIL modechg cyc %0d: got %h want %h", i, act_bus, exp_bus);
      end
      if (out_den && fd == 0) begin
        n_cmp++;
        if (out_data !== 8'h5A) begin
          n_fail++;
          $display("FAIL modechg_flat cyc %0d: got %h want 5a", i, out_data);
        end
      end
      if (out_den && fd == 1) begin
        n_cmp++;
        if (out_data !== 8'(ramp_x)) begin
          n_fail++;
          $display("FAIL modechg_ramp cyc %0d: got %h want %h", i, out_data, 8'(ramp_x));
        end
        ramp_x++;
      end else begin
        ramp_x = 0;
      end
      if (frame_done) fd++;
    end
  endtask

  task automatic test_reset_mid();
    int hs_cnt;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    enable = 1'b1;
    pattern_mode = 2'd0;
    hs_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      reset = (i == 70);
      cycle();
      n_cmp++;
      if (act_bus !== exp_bus) begin
        n_fail++;
        $display("FAIL rstmid cyc %0d: got %h want %h", i, act_bus, exp_bus);
      end
      if (i == 70) begin
        n_cmp++;
        if (act_bus !== 13'h0) begin
          n_fail++;
          $display("FAIL rstmid_clear: got %h want 0000", act_bus);
        end
      end
      if (i == 72) begin
        n_cmp++;
        if ({out_vsync, out_hsync} !== 2'b11) begin
          n_fail++;
          $display("FAIL rstmid_restart: got v/h=%b%b want 11", out_vsync, out_hsync);
        end
      end
      if (i > 70 && i <= 84 && out_hsync) hs_cnt++;
    end
    n_cmp++;
    if (hs_cnt != HS) begin
      n_fail++;
      $display("FAIL rstmid_hsync_len: got %0d want %0d", hs_cnt, HS);
    end
  endtask

  task automatic test_checker_wrap();
    int fd, checked;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    enable = 1'b1;
    pattern_mode = 2'd3;
    fd = 0; checked = 0;
    for (int i = 0; i < 257 * FRAME + 100 && checked == 0; i++) begin
      pattern_value = 8'($urandom);
      cycle();
      n_cmp++;
      if (act_bus !== exp_bus) begin
        n_fail++;
        $display("FAIL checker cyc %0d: got %h want %h", i, act_bus, exp_bus);
      end
      if (frame_done) fd++;
      if (fd == 256 && out_den) begin
        checked = 1;
        n_cmp++;
        if (out_data !== 8'h00) begin
          n_fail++;
          $display("FAIL checker_wrap: got %h want 00", out_data);
        end
      end
    end
    n_cmp++;
    if (checked == 0) begin
      n_fail++;
      $display("FAIL checker_timeout: got %0d frames want 256", fd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 3) != 0);
      pattern_mode = 2'($urandom);
      pattern_value = 8'($urandom);
      cycle();
      n_cmp++;
      if (act_bus !== exp_bus) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", i, act_bus, exp_bus);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_bayer();
    test_mid_disable();
    test_mode_change();
    test_reset_mid();
    test_checker_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
